mux_nx1_arb: RTL and testbench
==============================

MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001: Parameter WIDTH, default 4; data width of every channel and of the output.
REQ-002: Parameter N, default 4; number of input channels, legal range 2..16.
REQ-003: Parameter ARB_MODE, default 1; 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-004: Parameter SW = clog2(N); width of the selection index.
REQ-005: CLK  input  1  single clock; all state updates on its rising edge.
REQ-006: RSTN  input  1  reset, synchronous, active-low.
REQ-007: A  input  N*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-008: A_VALID  input  N  per-channel request; bit i means A slice i holds a word.
REQ-009: A_READY  output  N  per-channel accept; at most one bit set per cycle.
REQ-010: Y  output  WIDTH  registered selected data.
REQ-011: Y_SEL  output  SW  index of the channel that supplied Y.
REQ-012: Y_VALID  output  1  Y and Y_SEL hold a word.
REQ-013: Y_READY  input  1  downstream accepts Y this cycle.

Function
REQ-014: Transfer on channel i: A_VALID[i] & A_READY[i] at a rising edge; output transfer: Y_VALID & Y_READY at a rising edge.
REQ-015: Output stage is a one-entry register; "can_load" = !Y_VALID | Y_READY.
REQ-016: A_READY is combinational from A_VALID, priority state and can_load; no combinational path from A data to any output.
REQ-017: A_READY[i] = 1 only if can_load, A_VALID[i] = 1 and i is the highest-priority requesting channel; otherwise 0.
REQ-018: A_READY[i] never asserts for a channel with A_VALID[i] = 0; all A_READY = 0 when no channel requests.
REQ-019: ARB_MODE 0: priority order 0,1,...,N-1 every cycle.
REQ-020: ARB_MODE 1: priority starts at (LAST+1) mod N and wraps; LAST is the index of the most recent input transfer.
REQ-021: LAST updates only on an input transfer; unchanged on idle or stalled cycles.
REQ-022: On input transfer from channel i: next cycle Y = A slice i, Y_SEL = i, Y_VALID = 1 (latency one cycle).
REQ-023: Output transfer with no input transfer in the same cycle: Y_VALID clears; Y and Y_SEL hold their last values.
REQ-024: Simultaneous output and input transfer: register reloads with the new word, Y_VALID stays 1; sustained throughput one word per cycle.
REQ-025: Y_VALID = 1 and Y_READY = 0: Y, Y_SEL, Y_VALID held stable and all A_READY = 0 (backpressure).
REQ-026: Channel with A_VALID held high and no grant keeps waiting; in ARB_MODE 1 every requester is granted within N input transfers.
REQ-027: N not a power of two: wrap from N-1 to 0; indices >= N never produced.

Reset
REQ-028: RSTN = 0 at a rising edge: Y_VALID = 0, Y = 0, Y_SEL = 0, LAST = N-1 (channel 0 highest priority after reset).
REQ-029: A_READY = 0 while RSTN = 0; no transfer occurs in a reset cycle.
REQ-030: Reset mid-operation discards the held word without an output transfer; first post-reset grant follows REQ-028 priority.

Verification (N=4, WIDTH=8, ARB_MODE=1 unless stated)
REQ-031: Reset, then A_VALID=4'b0100, A slice 2 = 8'h5A, Y_READY=1 -> A_READY=4'b0100; next cycle Y=8'h5A, Y_SEL=2, Y_VALID=1.
REQ-032: All four A_VALID held high, Y_READY=1, data = channel index -> Y_SEL sequence 0,1,2,3,0,... one per cycle, Y_VALID continuously 1.
REQ-033: Y_VALID=1 with Y=8'h11, Y_READY=0 for 5 cycles while all A_VALID high -> Y stays 8'h11, A_READY=4'b0000 throughout; on Y_READY=1, same-cycle grant to next channel.
REQ-034: ARB_MODE=0, A_VALID=4'b1010 held, Y_READY=1 -> channel 1 granted every cycle, channel 3 never granted.
REQ-035: N=3, A_VALID=3'b111 held -> Y_SEL sequence 0,1,2,0,1,2; never 3.
REQ-036: RSTN low one cycle while Y_VALID=1, LAST=1 -> next cycle Y_VALID=0, Y=0, Y_SEL=0; with A_VALID=4'b1111, first grant is channel 0.

Source files
------------

// File: rtl/mux_nx1_arb_if.sv
// Handshake bundle for the N-to-1 arbitrated mux: N request channels in, one
// registered output channel out.
interface mux_nx1_arb_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) ();
  logic [N*WIDTH-1:0] a;
  logic [N-1:0]       a_valid;
  logic [N-1:0]       a_ready;
  logic [WIDTH-1:0]   y;
  logic [SW-1:0]      y_sel;
  logic               y_valid;
  logic               y_ready;

  modport master (
    output a, a_valid, y_ready,
    input  a_ready, y, y_sel, y_valid
  );

  modport slave (
    input  a, a_valid, y_ready,
    output a_ready, y, y_sel, y_valid
  );
endinterface

// File: rtl/mux_nx1_arb.sv
// N-to-1 mux with fixed-priority or round-robin arbitration feeding a one-entry
// output register; grants are issued only when that register can take a word.
module mux_nx1_arb #(
  parameter int WIDTH    = 4,
  parameter int N        = 4,
  parameter int ARB_MODE = 1,
  parameter int SW       = $clog2(N)
) (
  input logic          clk,
  input logic          rstn,
  mux_nx1_arb_if.slave bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    last_q, last_d;
  logic             valid_q, valid_d;

  logic             can_load;
  logic             found;
  logic             in_xfer;
  logic [SW-1:0]    grant_idx;
  logic [N-1:0]     grant_vec;
  logic [WIDTH-1:0] sel_data;
  int               start;
  int               idx;

  // Scan channels starting just after the last winner (or at 0 in fixed mode),
  // wrapping at N so indices beyond N-1 are never considered.
  always_comb begin
    can_load  = !valid_q || bus.y_ready;
    found     = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    idx       = 0;
    if (ARB_MODE == 0 || int'(last_q) >= N - 1) begin
      start = 0;
    end else begin
      start = int'(last_q) + 1;
    end
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && bus.a_valid[idx]) begin
        found     = 1'b1;
        grant_idx = SW'(idx);
      end
    end
    if (rstn && can_load && found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign in_xfer  = |grant_vec;
  assign sel_data = bus.a[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (in_xfer) begin
      y_d     = sel_data;
      sel_d   = grant_idx;
      valid_d = 1'b1;
      last_d  = grant_idx;
    end else if (valid_q && bus.y_ready) begin
      valid_d = 1'b0;
    end
  end

  // Reset leaves LAST at N-1 so channel 0 is first in line afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SW'(N - 1);
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.a_ready = grant_vec;
  assign bus.y       = y_q;
  assign bus.y_sel   = sel_q;
  assign bus.y_valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: three instances (N=4 round-robin, N=4 fixed, N=3
// round-robin) checked every cycle against a queue-free arithmetic model.
module tb_mux_nx1_arb;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0]  in_valid  [3];
  logic [31:0] in_data   [3];
  logic        in_yready [3];
  logic [3:0]  out_ready [3];
  logic [7:0]  out_y     [3];
  logic [1:0]  out_sel   [3];
  logic        out_yv    [3];

  mux_nx1_arb_if #(.WIDTH(W), .N(4), .SW(2)) if_rr ();
  mux_nx1_arb_if #(.WIDTH(W), .N(4), .SW(2)) if_fp ();
  mux_nx1_arb_if #(.WIDTH(W), .N(3), .SW(2)) if_n3 ();

  mux_nx1_arb #(.WIDTH(W), .N(4), .ARB_MODE(1), .SW(2)) dut_rr (.clk(clk), .rstn(rstn), .bus(if_rr));
  mux_nx1_arb #(.WIDTH(W), .N(4), .ARB_MODE(0), .SW(2)) dut_fp (.clk(clk), .rstn(rstn), .bus(if_fp));
  mux_nx1_arb #(.WIDTH(W), .N(3), .ARB_MODE(1), .SW(2)) dut_n3 (.clk(clk), .rstn(rstn), .bus(if_n3));

  assign if_rr.a       = in_data[0];
  assign if_rr.a_valid = in_valid[0];
  assign if_rr.y_ready = in_yready[0];
  assign if_fp.a       = in_data[1];
  assign if_fp.a_valid = in_valid[1];
  assign if_fp.y_ready = in_yready[1];
  assign if_n3.a       = in_data[2][23:0];
  assign if_n3.a_valid = in_valid[2][2:0];
  assign if_n3.y_ready = in_yready[2];

  assign out_ready[0] = if_rr.a_ready;
  assign out_ready[1] = if_fp.a_ready;
  assign out_ready[2] = {1'b0, if_n3.a_ready};
  assign out_y[0]     = if_rr.y;
  assign out_y[1]     = if_fp.y;
  assign out_y[2]     = if_n3.y;
  assign out_sel[0]   = if_rr.y_sel;
  assign out_sel[1]   = if_fp.y_sel;
  assign out_sel[2]   = if_n3.y_sel;
  assign out_yv[0]    = if_rr.y_valid;
  assign out_yv[1]    = if_fp.y_valid;
  assign out_yv[2]    = if_n3.y_valid;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Reference model: register contents plus index of the most recent winner.
  int         n_of    [3] = '{4, 4, 3};
  int         mode_of [3] = '{1, 0, 1};
  int         m_last  [3];
  int         m_sel   [3];
  logic [7:0] m_y     [3];
  bit         m_yv    [3];
  bit         model_init = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int         g;
      int         idx;
      bit         room;
      logic [3:0] exp_ready;
      g    = -1;
      room = !m_yv[i] || in_yready[i];
      if (rstn && room) begin
        for (int k = 0; k < n_of[i]; k++) begin
          idx = (mode_of[i] == 1) ? (m_last[i] + 1 + k) % n_of[i] : k;
          if (g < 0 && in_valid[i][idx]) g = idx;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      if (model_init) begin
        checkOutput($sformatf("m%0d a_ready", i), 32'(out_ready[i]), 32'(exp_ready));
        checkOutput($sformatf("m%0d y", i),       32'(out_y[i]),     32'(m_y[i]));
        checkOutput($sformatf("m%0d y_sel", i),   32'(out_sel[i]),   32'(m_sel[i]));
        checkOutput($sformatf("m%0d y_valid", i), 32'(out_yv[i]),    32'(m_yv[i]));
      end
      if (!rstn) begin
        m_y[i]    = '0;
        m_sel[i]  = 0;
        m_yv[i]   = 1'b0;
        m_last[i] = n_of[i] - 1;
      end else if (g >= 0) begin
        m_y[i]    = in_data[i][g*8 +: 8];
        m_sel[i]  = g;
        m_yv[i]   = 1'b1;
        m_last[i] = g;
      end else if (m_yv[i] && in_yready[i]) begin
        m_yv[i] = 1'b0;
      end
    end
    if (!rstn) model_init = 1'b1;
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = '0;
      in_data[i]   = '0;
      in_yready[i] = 1'b1;
    end
    rstn = 1'b0;
    repeat (2) applyStimulus();

    // Requests during reset must not be granted
    in_valid[0] = 4'hF;
    #1;
    checkOutput("reset a_ready", 32'(out_ready[0]), 32'h0);
    applyStimulus();
    #1;
    checkOutput("reset y_valid", 32'(out_yv[0]), 32'h0);
    checkOutput("reset y", 32'(out_y[0]), 32'h0);
    checkOutput("reset y_sel", 32'(out_sel[0]), 32'h0);

    // Single request on channel 2
    rstn        = 1'b1;
    in_valid[0] = 4'b0100;
    in_data[0]  = 32'h005A_0000;
    #1;
    checkOutput("ch2 a_ready", 32'(out_ready[0]), 32'h4);
    applyStimulus();
    in_valid[0] = 4'b0000;
    #1;
    checkOutput("ch2 y", 32'(out_y[0]), 32'h5A);
    checkOutput("ch2 y_sel", 32'(out_sel[0]), 32'h2);
    checkOutput("ch2 y_valid", 32'(out_yv[0]), 32'h1);
    applyStimulus();
    #1;
    checkOutput("drain y_valid", 32'(out_yv[0]), 32'h0);
    checkOutput("drain y hold", 32'(out_y[0]), 32'h5A);

    // Fresh reset, then all four requesting: rotation 0,1,2,3,0
    rstn = 1'b0;
    applyStimulus();
    rstn        = 1'b1;
    in_valid[0] = 4'hF;
    in_data[0]  = 32'h0302_0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("rot a_ready", 32'(out_ready[0]), 32'(1 << (k % 4)));
      if (k > 0) begin
        checkOutput("rot y_sel", 32'(out_sel[0]), 32'((k - 1) % 4));
        checkOutput("rot y", 32'(out_y[0]), 32'((k - 1) % 4));
        checkOutput("rot y_valid", 32'(out_yv[0]), 32'h1);
      end
      applyStimulus();
    end
    in_data[0] = 32'h1111_1111;
    #1;
    checkOutput("rot last y_sel", 32'(out_sel[0]), 32'h0);
    checkOutput("rot next grant", 32'(out_ready[0]), 32'h2);
    applyStimulus();

    // Backpressure: word 8'h11 from channel 1 held for five cycles
    in_yready[0] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput("stall y", 32'(out_y[0]), 32'h11);
      checkOutput("stall y_valid", 32'(out_yv[0]), 32'h1);
      checkOutput("stall a_ready", 32'(out_ready[0]), 32'h0);
      applyStimulus();
    end
    in_yready[0] = 1'b1;
    #1;
    checkOutput("unstall grant", 32'(out_ready[0]), 32'h4);
    applyStimulus();
    #1;
    checkOutput("unstall y_sel", 32'(out_sel[0]), 32'h2);
    checkOutput("unstall y_valid", 32'(out_yv[0]), 32'h1);

    // Reset while holding a word with LAST=1
    in_valid[0] = 4'b0010;
    #1;
    checkOutput("pre-reset grant", 32'(out_ready[0]), 32'h2);
    applyStimulus();
    rstn        = 1'b0;
    in_valid[0] = 4'hF;
    #1;
    checkOutput("midreset a_ready", 32'(out_ready[0]), 32'h0);
    checkOutput("midreset y_valid", 32'(out_yv[0]), 32'h1);
    applyStimulus();
    rstn = 1'b1;
    #1;
    checkOutput("postreset y_valid", 32'(out_yv[0]), 32'h0);
    checkOutput("postreset y", 32'(out_y[0]), 32'h0);
    checkOutput("postreset y_sel", 32'(out_sel[0]), 32'h0);
    checkOutput("postreset grant", 32'(out_ready[0]), 32'h1);
    in_valid[0] = 4'b0000;

    // Fixed priority: channel 1 always beats channel 3
    in_valid[1] = 4'b1010;
    in_data[1]  = 32'hD3C2_B1A0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("fixed a_ready", 32'(out_ready[1]), 32'h2);
      if (k > 0) begin
        checkOutput("fixed y_sel", 32'(out_sel[1]), 32'h1);
        checkOutput("fixed y", 32'(out_y[1]), 32'hB1);
      end
      applyStimulus();
    end
    in_valid[1] = 4'b0000;

    // N=3 wraps 2 -> 0
    in_valid[2] = 4'b0111;
    in_data[2]  = 32'h0002_0100;
    for (int k = 0; k < 7; k++) begin
      #1;
      checkOutput("n3 a_ready", 32'(out_ready[2]), 32'(1 << (k % 3)));
      if (k > 0) checkOutput("n3 y_sel", 32'(out_sel[2]), 32'((k - 1) % 3));
      applyStimulus();
    end
    in_valid[2] = 4'b0000;

    // Random traffic with occasional resets, checked by the model
    repeat (600) begin
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        if (i == 2) in_valid[i][3] = 1'b0;
        in_data[i]   = $urandom;
        in_yready[i] = ($urandom_range(0, 3) != 0);
      end
      rstn = ($urandom_range(0, 63) != 0);
    end
    applyStimulus();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) in_valid[i] = '0;
    repeat (3) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
